// File: rtl/vga_dither_out.sv
// VGA output stage: full-depth RGB to narrow DAC pins with ordered (Bayer) dithering.
// Two-stage pipeline, syncs delayed to match; optional frame rotation via VGA_DITHER_TEMPORAL_EN.
//
// Ports:
//   CLK_25MHZ                   pixel clock
//   RESET                       asynchronous, active-high reset
//   VGA_HSYNC_IN / VGA_VSYNC_IN syncs from the core
//   VGA_{RED,GREEN,BLUE}_IN     IN_BITS colour per channel from the core
//   VGA_HSYNC / VGA_VSYNC       syncs delayed two cycles
//   VGA_{RED,GREEN,BLUE}        OUT_BITS dithered colour per channel
//
// Parameters: IN_BITS, OUT_BITS (1..IN_BITS), DITHER_N (2 or 4),
//   HSYNC_POL / VSYNC_POL (active level, 0 = active-low).
// Macro VGA_DITHER_TEMPORAL_EN: a 2-bit frame counter offsets the matrix
//   lookup every frame; undefined gives a static pattern.

module vga_dither_out #(
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 4,
  parameter int DITHER_N  = 4,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                CLK_25MHZ,
  input  logic                RESET,
  input  logic                VGA_HSYNC_IN,
  input  logic                VGA_VSYNC_IN,
  input  logic [IN_BITS-1:0]  VGA_RED_IN,
  input  logic [IN_BITS-1:0]  VGA_GREEN_IN,
  input  logic [IN_BITS-1:0]  VGA_BLUE_IN,
  output logic                VGA_HSYNC,
  output logic                VGA_VSYNC,
  output logic [OUT_BITS-1:0] VGA_RED,
  output logic [OUT_BITS-1:0] VGA_GREEN,
  output logic [OUT_BITS-1:0] VGA_BLUE
);

  // Position index width and matrix value width (L = 2*log2(N)).
  localparam int PW   = (DITHER_N > 2) ? 2 : 1;
  localparam int L    = 2 * PW;
  localparam int D    = IN_BITS - OUT_BITS;
  localparam int SW   = IN_BITS + 1;
  localparam int QW   = OUT_BITS + 1;
  // Only one of these is non-zero: scale B up or down to D bits.
  localparam int SH_L = (D >= L) ? (D - L) : 0;
  localparam int SH_R = (D >= L) ? 0 : (L - D);

  // ---------------- stage 1 ----------------
  logic               r_hs1;
  logic               r_vs1;
  logic [IN_BITS-1:0] r_red1;
  logic [IN_BITS-1:0] r_grn1;
  logic [IN_BITS-1:0] r_blu1;
  logic [PW-1:0]      r_x;
  logic [PW-1:0]      r_y;

  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_hs_edge;
  logic          w_vs_edge;
  logic [PW-1:0] w_x_nxt;
  logic [PW-1:0] w_y_nxt;

  // r_hs1/r_vs1 double as the previous-sample registers.
  assign w_hs_act  = (VGA_HSYNC_IN == HSYNC_POL);
  assign w_vs_act  = (VGA_VSYNC_IN == VSYNC_POL);
  assign w_hs_edge = w_hs_act && (r_hs1 != HSYNC_POL);
  assign w_vs_edge = w_vs_act && (r_vs1 != VSYNC_POL);

  // Vsync edge takes priority on y; x restarts on any hsync edge.
  always_comb begin
    w_x_nxt = r_x + PW'(1);
    if (w_hs_edge) begin
      w_x_nxt = '0;
    end
    w_y_nxt = r_y;
    if (w_vs_edge) begin
      w_y_nxt = '0;
    end else if (w_hs_edge) begin
      w_y_nxt = r_y + PW'(1);
    end
  end

  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      r_hs1  <= ~HSYNC_POL;
      r_vs1  <= ~VSYNC_POL;
      r_red1 <= '0;
      r_grn1 <= '0;
      r_blu1 <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_hs1  <= VGA_HSYNC_IN;
      r_vs1  <= VGA_VSYNC_IN;
      r_red1 <= VGA_RED_IN;
      r_grn1 <= VGA_GREEN_IN;
      r_blu1 <= VGA_BLUE_IN;
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
    end
  end

  // ---------------- matrix lookup ----------------
  logic [PW-1:0] w_xl;
  logic [PW-1:0] w_yl;

`ifdef VGA_DITHER_TEMPORAL_EN
  logic [1:0] r_f;

  // Frame counter advances with the position counters so the
  // whole new frame, including its first pixel, uses the new offset.
  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      r_f <= '0;
    end else if (w_vs_edge) begin
      r_f <= r_f + 2'd1;
    end
  end

  assign w_xl = r_x + PW'(r_f[0]);
  assign w_yl = r_y + PW'(r_f[1]);
`else
  assign w_xl = r_x;
  assign w_yl = r_y;
`endif

  logic [1:0] w_x2;
  logic [1:0] w_y2;
  logic [3:0] w_b;

  assign w_x2 = 2'(w_xl);
  assign w_y2 = 2'(w_yl);

  always_comb begin
    w_b = '0;
    if (DITHER_N == 2) begin
      case ({w_y2[0], w_x2[0]})
        2'b00:   w_b = 4'd0;
        2'b01:   w_b = 4'd2;
        2'b10:   w_b = 4'd3;
        default: w_b = 4'd1;
      endcase
    end else begin
      case ({w_y2, w_x2})
        4'h0:    w_b = 4'd0;
        4'h1:    w_b = 4'd8;
        4'h2:    w_b = 4'd2;
        4'h3:    w_b = 4'd10;
        4'h4:    w_b = 4'd12;
        4'h5:    w_b = 4'd4;
        4'h6:    w_b = 4'd14;
        4'h7:    w_b = 4'd6;
        4'h8:    w_b = 4'd3;
        4'h9:    w_b = 4'd11;
        4'hA:    w_b = 4'd1;
        4'hB:    w_b = 4'd9;
        4'hC:    w_b = 4'd15;
        4'hD:    w_b = 4'd7;
        4'hE:    w_b = 4'd13;
        default: w_b = 4'd5;
      endcase
    end
  end

  // Threshold t < 2^D; D = 0 shifts B out entirely, giving t = 0.
  logic [3:0]    w_bs;
  logic [SW-1:0] w_t;

  assign w_bs = w_b >> SH_R;
  assign w_t  = SW'(w_bs) << SH_L;

  // ---------------- stage 2 ----------------
  // Add at IN_BITS+1 width, drop D bits, clamp the carry case.
  function automatic logic [OUT_BITS-1:0] dq(
    input logic [IN_BITS-1:0] c,
    input logic [SW-1:0]      t
  );
    logic [SW-1:0] s;
    logic [QW-1:0] q;
    s = {1'b0, c} + t;
    q = QW'(s >> D);
    return q[OUT_BITS] ? '1 : q[OUT_BITS-1:0];
  endfunction

  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      VGA_HSYNC <= ~HSYNC_POL;
      VGA_VSYNC <= ~VSYNC_POL;
      VGA_RED   <= '0;
      VGA_GREEN <= '0;
      VGA_BLUE  <= '0;
    end else begin
      VGA_HSYNC <= r_hs1;
      VGA_VSYNC <= r_vs1;
      VGA_RED   <= dq(r_red1, w_t);
      VGA_GREEN <= dq(r_grn1, w_t);
      VGA_BLUE  <= dq(r_blu1, w_t);
    end
  end

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: three instances (defaults, 8-bit pass-through,
// 2x2 matrix with active-high hsync) checked against a reference-model scoreboard.

module tb_vga_dither_out;

`ifdef VGA_DITHER_TEMPORAL_EN
  localparam bit TEMP = 1'b1;
`else
  localparam bit TEMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       hs_in, vs_in;
  logic [7:0] r_in, g_in, b_in;

  always #5 clk = ~clk;

  logic       a_hs, a_vs, b_hs, b_vs, c_hs, c_vs;
  logic [3:0] a_r, a_g, a_b, c_r, c_g, c_b;
  logic [7:0] b_r, b_g, b_b;

  vga_dither_out dut_a (
    .CLK_25MHZ(clk), .RESET(rst),
    .VGA_HSYNC_IN(hs_in), .VGA_VSYNC_IN(vs_in),
    .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
    .VGA_HSYNC(a_hs), .VGA_VSYNC(a_vs),
    .VGA_RED(a_r), .VGA_GREEN(a_g), .VGA_BLUE(a_b)
  );

  vga_dither_out #(.OUT_BITS(8)) dut_b (
    .CLK_25MHZ(clk), .RESET(rst),
    .VGA_HSYNC_IN(hs_in), .VGA_VSYNC_IN(vs_in),
    .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
    .VGA_HSYNC(b_hs), .VGA_VSYNC(b_vs),
    .VGA_RED(b_r), .VGA_GREEN(b_g), .VGA_BLUE(b_b)
  );

  vga_dither_out #(.DITHER_N(2), .HSYNC_POL(1'b1)) dut_c (
    .CLK_25MHZ(clk), .RESET(rst),
    .VGA_HSYNC_IN(hs_in), .VGA_VSYNC_IN(vs_in),
    .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
    .VGA_HSYNC(c_hs), .VGA_VSYNC(c_vs),
    .VGA_RED(c_r), .VGA_GREEN(c_g), .VGA_BLUE(c_b)
  );

  typedef struct packed {
    logic       ahs, avs;
    logic [3:0] ar, ag, ab;
    logic       bhs, bvs;
    logic [7:0] br, bg, bb;
    logic       chs, cvs;
    logic [3:0] cr, cg, cb;
  } out_t;

  typedef struct {
    out_t o;
    int   tag;
  } sb_t;

  typedef struct {
    bit hp;
    bit vp;
    int x;
    int y;
    int f;
  } pos_t;

  int   n_chk = 0;
  int   n_pass = 0;
  sb_t  sbq[$];
  pos_t pa, pc;
  out_t rst_o;
  logic [3:0] ga[16];
  logic [3:0] gc[16];
  int   bay4[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6},
                       '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  int   bay2[2][2] = '{'{0, 2}, '{3, 1}};

  function automatic out_t sample();
    return {a_hs, a_vs, a_r, a_g, a_b, b_hs, b_vs, b_r, b_g, b_b,
            c_hs, c_vs, c_r, c_g, c_b};
  endfunction

  function automatic pos_t pos_step(input pos_t p, input bit ha,
                                    input bit va, input int n);
    pos_t q;
    bit he, ve;
    q = p;
    he = ha && !p.hp;
    ve = va && !p.vp;
    q.x = he ? 0 : (p.x + 1) % n;
    if (ve) begin
      q.y = 0;
      q.f = (p.f + 1) % 4;
    end else if (he) begin
      q.y = (p.y + 1) % n;
    end
    q.hp = ha;
    q.vp = va;
    return q;
  endfunction

  function automatic logic [3:0] dith(input logic [7:0] c, input pos_t p,
                                      input int n);
    int xi, yi, t, v;
    xi = p.x;
    yi = p.y;
    if (TEMP) begin
      xi = (xi + p.f % 2) % n;
      yi = (yi + p.f / 2) % n;
    end
    if (n == 4) t = bay4[yi][xi];
    else t = 4 * bay2[yi][xi];
    v = (int'(c) + t) / 16;
    if (v > 15) v = 15;
    return 4'(v);
  endfunction

  task automatic model_reset();
    pa = '{hp: 1'b0, vp: 1'b0, x: 0, y: 0, f: 0};
    pc = pa;
    sbq.delete();
  endtask

  // Drive one pixel, push its expected outputs, advance one clock.
  task automatic cyc(input logic hs, input logic vs, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b, input int tag);
    sb_t e;
    hs_in = hs; vs_in = vs;
    r_in = r; g_in = g; b_in = b;
    pa = pos_step(pa, hs == 1'b0, vs == 1'b0, 4);
    pc = pos_step(pc, hs == 1'b1, vs == 1'b0, 2);
    e.o.ahs = hs; e.o.avs = vs;
    e.o.ar = dith(r, pa, 4); e.o.ag = dith(g, pa, 4); e.o.ab = dith(b, pa, 4);
    e.o.bhs = hs; e.o.bvs = vs;
    e.o.br = r; e.o.bg = g; e.o.bb = b;
    e.o.chs = hs; e.o.cvs = vs;
    e.o.cr = dith(r, pc, 2); e.o.cg = dith(g, pc, 2); e.o.cb = dith(b, pc, 2);
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb_t e;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hs_in = 1'($urandom); vs_in = 1'($urandom);
      r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
      @(posedge clk);
      #1;
      n_chk++;
      if (sample() !== rst_o)
        $display("FAIL reset_hold got=%h exp=%h", sample(), rst_o);
      else n_pass++;
    end
    hs_in = 1'b1; vs_in = 1'b1; r_in = '0; g_in = '0; b_in = '0;
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, -1);
      if (sbq.size() == 2) begin
        e = sbq.pop_front();
        n_chk++;
        if (sample() !== e.o)
          $display("FAIL reset_zero got=%h exp=%h", sample(), e.o);
        else n_pass++;
      end
    end
    n_chk++;
    if ({a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b} !== '0)
      $display("FAIL reset_zero_colors got=%h exp=0",
               {a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b});
    else n_pass++;
  endtask

  task automatic test_passthrough();
    sb_t e;
    for (int i = 0; i < 256; i++) begin
      cyc(1'((i % 16) != 0), 1'((i % 64) != 3),
          8'(i), 8'(255 - i), 8'(i) ^ 8'h55, -1);
      if (sbq.size() == 2) begin
        e = sbq.pop_front();
        n_chk++;
        if (sample() !== e.o)
          $display("FAIL passthrough got=%h exp=%h", sample(), e.o);
        else n_pass++;
      end
    end
  endtask

  // Four lines of four pixels starting on simultaneous sync edges.
  task automatic run_grid(input logic [7:0] c, input string nm);
    sb_t e;
    for (int i = 0; i < 16; i++) begin
      ga[i] = '0;
      gc[i] = '0;
    end
    for (int k = 0; k < 22; k++) begin
      if (k < 2 || k >= 18) cyc(1'b1, 1'b1, c, c, c, -1);
      else if ((k - 2) % 4 == 0) cyc(1'b0, 1'(k != 2), c, c, c, k - 2);
      else cyc(1'b1, 1'b1, c, c, c, k - 2);
      if (sbq.size() == 2) begin
        e = sbq.pop_front();
        n_chk++;
        if (sample() !== e.o)
          $display("FAIL %s px=%0d got=%h exp=%h", nm, e.tag, sample(), e.o);
        else n_pass++;
        if (e.tag >= 0) ga[e.tag] = a_r;
      end
    end
  endtask

  task automatic test_dither();
    int nines;
    logic [15:0] row0;
    run_grid(8'h88, "dither");
    if (!TEMP) begin
      nines = 0;
      for (int i = 0; i < 16; i++) if (ga[i] == 4'd9) nines++;
      n_chk++;
      if (nines != 8) $display("FAIL dither_count got=%0d exp=8", nines);
      else n_pass++;
      row0 = {ga[0], ga[1], ga[2], ga[3]};
      n_chk++;
      if (row0 !== 16'h8989)
        $display("FAIL dither_row0 got=%h exp=8989", row0);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int sat;
    run_grid(8'hFF, "saturation");
    sat = 0;
    for (int i = 0; i < 16; i++) if (ga[i] === 4'hF) sat++;
    n_chk++;
    if (sat != 16) $display("FAIL saturation_all got=%0d exp=16", sat);
    else n_pass++;
  endtask

  // Exercises dut_c: active-high hsync, simultaneous edges, second line.
  task automatic test_sync_edges();
    sb_t e;
    logic [15:0] got;
    logic       hs_s[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       vs_s[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int         tg[10] = '{-1, -1, -1, 0, 1, -1, -1, -1, 2, 3};
    for (int k = 0; k < 12; k++) begin
      if (k < 10) cyc(hs_s[k], vs_s[k], 8'h88, 8'h88, 8'h88, tg[k]);
      else cyc(1'b1, 1'b1, 8'h88, 8'h88, 8'h88, -1);
      if (sbq.size() == 2) begin
        e = sbq.pop_front();
        n_chk++;
        if (sample() !== e.o)
          $display("FAIL sync_edges got=%h exp=%h", sample(), e.o);
        else n_pass++;
        if (e.tag >= 0) gc[e.tag] = c_r;
      end
    end
    if (!TEMP) begin
      got = {gc[0], gc[1], gc[2], gc[3]};
      n_chk++;
      if (got !== 16'h8998)
        $display("FAIL sync_pol_hi got=%h exp=8998", got);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    sb_t e;
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 31) != 0),
          8'($urandom), 8'($urandom), 8'($urandom), -1);
      if (sbq.size() == 2) begin
        e = sbq.pop_front();
        n_chk++;
        if (sample() !== e.o)
          $display("FAIL random got=%h exp=%h", sample(), e.o);
        else n_pass++;
      end
    end
  endtask

`ifdef VGA_DITHER_TEMPORAL_EN
  task automatic test_temporal();
    sb_t e;
    int  fk[4];
    logic [3:0] pat[4] = '{4'd8, 4'd9, 4'd9, 4'd8};
    for (int fr = 0; fr < 4; fr++) begin
      for (int k = 0; k < 8; k++) begin
        if (k == 2) begin
          cyc(1'b0, 1'b0, 8'h88, 8'h88, 8'h88, fr);
          fk[fr] = pa.f;
        end else begin
          cyc(1'b1, 1'b1, 8'h88, 8'h88, 8'h88, -1);
        end
        if (sbq.size() == 2) begin
          e = sbq.pop_front();
          n_chk++;
          if (sample() !== e.o)
            $display("FAIL temporal got=%h exp=%h", sample(), e.o);
          else n_pass++;
          if (e.tag >= 0) ga[e.tag] = a_r;
        end
      end
    end
    for (int fr = 0; fr < 4; fr++) begin
      n_chk++;
      if (ga[fr] !== pat[fk[fr]])
        $display("FAIL temporal_px00 f=%0d got=%0d exp=%0d",
                 fk[fr], ga[fr], pat[fk[fr]]);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_midreset();
    sb_t e;
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, 8'hC3, 8'h7E, 8'hA5, -1);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (sample() !== rst_o)
      $display("FAIL midreset_async got=%h exp=%h", sample(), rst_o);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if (sample() !== rst_o)
      $display("FAIL midreset_hold got=%h exp=%h", sample(), rst_o);
    else n_pass++;
    hs_in = 1'b1; vs_in = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), -1);
      if (sbq.size() == 2) begin
        e = sbq.pop_front();
        n_chk++;
        if (sample() !== e.o)
          $display("FAIL midreset_resume got=%h exp=%h", sample(), e.o);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    hs_in = 1'b1; vs_in = 1'b1;
    r_in = '0; g_in = '0; b_in = '0;
    rst_o = '0;
    rst_o.ahs = 1'b1; rst_o.avs = 1'b1;
    rst_o.bhs = 1'b1; rst_o.bvs = 1'b1;
    rst_o.chs = 1'b0; rst_o.cvs = 1'b1;
    model_reset();
    test_reset();
    test_passthrough();
    test_dither();
    test_saturation();
    test_sync_edges();
    test_random();
`ifdef VGA_DITHER_TEMPORAL_EN
    test_temporal();
`endif
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
